// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi channel injector and its helpers.
package viterbi_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_RANDOM   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BURST = 2'd2
  } inj_state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/viterbi_channel_injector_lfsr16.sv
// 16-bit Galois LFSR (taps 0xB400, shift right); advances once per adv cycle.
module lfsr16
  import viterbi_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] r_q;

  // State register; a non-zero seed keeps the sequence off the all-zero lockup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= SEED;
    end else if (adv) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/viterbi_channel_injector.sv
// Channel model between convolutional encoder and Viterbi decoder: corrupts
// symbols in pass/periodic/burst/random modes and keeps saturating statistics.
module viterbi_channel_injector
  import viterbi_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned WIN   = 32,
  parameter int unsigned LEN_W = 4,
  parameter logic [15:0] SEED  = DEFAULT_SEED,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [W-1:0]     sym_i,
  input  logic [1:0]       mode_i,
  input  logic [W-1:0]     lane_mask_i,
  input  logic [15:0]      period_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [15:0]      thresh_i,
  input  logic             clr_i,
  output logic             valid_o,
  output logic [W-1:0]     sym_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] inj_sym_ct_o,
  output logic [CNT_W-1:0] inj_bit_ct_o
);

  localparam int unsigned WIN_W  = $clog2(WIN);
  localparam int unsigned PCNT_W = $clog2(W + 1);

  logic             r_valid;
  logic [W-1:0]     r_sym;
  logic             r_err;
  logic             r_busy;
  logic [CNT_W-1:0] r_sym_ct;
  logic [CNT_W-1:0] r_bit_ct;
  logic [1:0]       r_mode_q;
  logic [WIN_W-1:0] r_win_ct;
  logic [15:0]      r_per_ct;
  inj_state_e       r_state;
  logic [WIN_W-1:0] r_off_ct;
  logic [LEN_W-1:0] r_len_ct;

  mode_e             w_mode;
  logic              w_mode_chg;
  logic              w_inj;
  logic [15:0]       w_lfsr;
  logic [PCNT_W-1:0] w_pop;
  logic [CNT_W:0]    w_sym_sum;
  logic [CNT_W:0]    w_bit_sum;

  assign w_mode     = mode_e'(mode_i);
  assign w_mode_chg = (mode_i != r_mode_q);

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (valid_i),
    .q   (w_lfsr)
  );

  // Injection decision for the current symbol; a mode change suppresses it.
  always_comb begin
    w_inj = 1'b0;
    if (!w_mode_chg) begin
      unique case (w_mode)
        MODE_PERIODIC: w_inj = (period_i != 16'd0) && (r_per_ct == period_i - 16'd1);
        MODE_BURST:    w_inj = (r_state == ST_BURST);
        MODE_RANDOM:   w_inj = (w_lfsr < thresh_i);
        default:       w_inj = 1'b0;
      endcase
    end
  end

  // Number of lanes flipped by one corrupted symbol.
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < W; i++) begin
      w_pop = w_pop + PCNT_W'(lane_mask_i[i]);
    end
  end

  assign w_sym_sum = {1'b0, r_sym_ct} + (CNT_W + 1)'(1);
  assign w_bit_sum = {1'b0, r_bit_ct} + (CNT_W + 1)'(w_pop);

  // Output datapath: one-cycle latency, symbol held across invalid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sym   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_sym <= sym_i ^ (w_inj ? lane_mask_i : '0);
        r_err <= w_inj && (lane_mask_i != '0);
      end else begin
        r_err <= 1'b0;
      end
    end
  end

  // Saturating statistics; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_ct <= '0;
      r_bit_ct <= '0;
    end else if (clr_i) begin
      r_sym_ct <= '0;
      r_bit_ct <= '0;
    end else if (valid_i && w_inj) begin
      r_sym_ct <= w_sym_sum[CNT_W] ? '1 : w_sym_sum[CNT_W-1:0];
      r_bit_ct <= w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
    end
  end

  // Mode history (every cycle) and the free-running burst window counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q <= '0;
      r_win_ct <= '0;
    end else begin
      r_mode_q <= mode_i;
      if (valid_i) begin
        r_win_ct <= r_win_ct + WIN_W'(1);
      end
    end
  end

  // Periodic spacing counter; also wraps if period_i shrinks below it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_ct <= '0;
    end else if (w_mode_chg) begin
      r_per_ct <= '0;
    end else if (valid_i && (w_mode == MODE_PERIODIC)) begin
      if ((period_i == 16'd0) || (r_per_ct >= period_i - 16'd1)) begin
        r_per_ct <= '0;
      end else begin
        r_per_ct <= r_per_ct + 16'd1;
      end
    end
  end

  // Burst FSM with registered busy flag tracking the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_off_ct <= '0;
      r_len_ct <= '0;
    end else if (w_mode_chg) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else if (valid_i && (w_mode == MODE_BURST)) begin
      unique case (r_state)
        ST_IDLE: begin
          if ((r_win_ct == '0) && w_lfsr[0] && (burst_len_i != '0)) begin
            r_off_ct <= w_lfsr[WIN_W:1];
            r_state  <= ST_ARMED;
            r_busy   <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (r_off_ct != '0) begin
            r_off_ct <= r_off_ct - WIN_W'(1);
          end else if (burst_len_i != '0) begin
            r_len_ct <= burst_len_i;
            r_state  <= ST_BURST;
          end else begin
            // Length dropped to zero while armed: nothing to inject.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_BURST: begin
          if (r_len_ct <= LEN_W'(1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_len_ct <= r_len_ct - LEN_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o      = r_valid;
  assign sym_o        = r_sym;
  assign err_o        = r_err;
  assign busy_o       = r_busy;
  assign inj_sym_ct_o = r_sym_ct;
  assign inj_bit_ct_o = r_bit_ct;

endmodule

// File: tb/tb_viterbi_channel_injector.sv
// Directed self-checking bench for viterbi_channel_injector (default parameters).
module tb_viterbi_channel_injector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  sym_i = '0;
  logic [1:0]  mode_i = '0;
  logic [1:0]  lane_mask_i = '0;
  logic [15:0] period_i = '0;
  logic [3:0]  burst_len_i = '0;
  logic [15:0] thresh_i = '0;
  logic        clr_i = 1'b0;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic        err_o;
  logic        busy_o;
  logic [31:0] inj_sym_ct_o;
  logic [31:0] inj_bit_ct_o;

  int n_assert = 0;
  int n_fail   = 0;

  viterbi_channel_injector #(
    .W     (2),
    .WIN   (32),
    .LEN_W (4),
    .SEED  (16'hACE1),
    .CNT_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .sym_i        (sym_i),
    .mode_i       (mode_i),
    .lane_mask_i  (lane_mask_i),
    .period_i     (period_i),
    .burst_len_i  (burst_len_i),
    .thresh_i     (thresh_i),
    .clr_i        (clr_i),
    .valid_o      (valid_o),
    .sym_o        (sym_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .inj_sym_ct_o (inj_sym_ct_o),
    .inj_bit_ct_o (inj_bit_ct_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [1:0] s);
    valid_i = v;
    sym_i   = s;
    @(posedge clk);
    #1;
  endtask

  // Reset pulse followed by one idle cycle so mode_q absorbs the current mode.
  task automatic do_reset();
    valid_i = 1'b0;
    clr_i   = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 2'b00);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid_o"}, valid_o, 0);
    chk({tag, "_sym_o"}, sym_o, 0);
    chk({tag, "_err_o"}, err_o, 0);
    chk({tag, "_busy_o"}, busy_o, 0);
    chk({tag, "_sym_ct"}, inj_sym_ct_o, 0);
    chk({tag, "_bit_ct"}, inj_bit_ct_o, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] s;
    logic [1:0] held;
    logic       e;
    logic       prev_err;
    logic       prev_busy;
    int         run;
    int         err_total;

    // ---- reset state ----
    @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    // ---- pass-through ----
    mode_i      = 2'd0;
    lane_mask_i = 2'b11;
    cyc(1'b0, 2'b00);
    for (int i = 0; i < 100; i++) begin
      s = 2'($urandom_range(0, 3));
      cyc(1'b1, s);
      chk("pass_sym", sym_o, s);
      chk("pass_err", err_o, 0);
      chk("pass_valid", valid_o, 1);
    end
    held = s;
    cyc(1'b0, 2'b00);
    chk("pass_gap_valid", valid_o, 0);
    chk("pass_gap_hold", sym_o, held);
    chk("pass_sym_ct", inj_sym_ct_o, 0);
    chk("pass_bit_ct", inj_bit_ct_o, 0);

    // ---- periodic, period 4, lane 1 ----
    mode_i      = 2'd1;
    period_i    = 16'd4;
    lane_mask_i = 2'b10;
    cyc(1'b0, 2'b00);
    for (int i = 0; i < 64; i++) begin
      s = 2'(i);
      e = ((i % 4) == 3);
      cyc(1'b1, s);
      chk("per4_sym", sym_o, s ^ (e ? 2'b10 : 2'b00));
      chk("per4_err", err_o, e);
    end
    chk("per4_sym_ct", inj_sym_ct_o, 16);
    chk("per4_bit_ct", inj_bit_ct_o, 16);

    // period 1: every symbol corrupted
    period_i    = 16'd1;
    lane_mask_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'b10);
      chk("per1_sym", sym_o, 2'b11);
      chk("per1_err", err_o, 1);
    end
    chk("per1_sym_ct", inj_sym_ct_o, 20);
    chk("per1_bit_ct", inj_bit_ct_o, 20);

    // period 0: never corrupted
    period_i = 16'd0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'b10);
      chk("per0_sym", sym_o, 2'b10);
      chk("per0_err", err_o, 0);
    end
    chk("per0_sym_ct", inj_sym_ct_o, 20);

    // clear coinciding with an injection
    period_i = 16'd1;
    clr_i    = 1'b1;
    cyc(1'b1, 2'b00);
    clr_i = 1'b0;
    chk("clr_err", err_o, 1);
    chk("clr_sym_ct", inj_sym_ct_o, 0);
    chk("clr_bit_ct", inj_bit_ct_o, 0);

    // ---- periodic with gaps, period 3 ----
    mode_i      = 2'd1;
    period_i    = 16'd3;
    lane_mask_i = 2'b10;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      e = ((i % 3) == 2);
      cyc(1'b1, 2'b01);
      chk("gap3_sym", sym_o, e ? 2'b11 : 2'b01);
      chk("gap3_err", err_o, e);
      cyc(1'b0, 2'b00);
      chk("gap3_idle_err", err_o, 0);
      chk("gap3_idle_hold", sym_o, e ? 2'b11 : 2'b01);
    end
    chk("gap3_sym_ct", inj_sym_ct_o, 3);

    // ---- random: directed from seed 0xACE1 (ACE1, E270, 7138, 389C, 1C4E) ----
    mode_i      = 2'd3;
    lane_mask_i = 2'b01;
    thresh_i    = 16'h8000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e = (i >= 2);
      cyc(1'b1, 2'b00);
      chk("rnd_err", err_o, e);
      chk("rnd_sym", sym_o, {1'b0, e});
    end
    chk("rnd_sym_ct", inj_sym_ct_o, 3);

    // threshold boundary around the first LFSR value
    thresh_i = 16'hACE1;
    do_reset();
    cyc(1'b1, 2'b00);
    chk("rnd_thr_eq", err_o, 0);
    thresh_i = 16'hACE2;
    do_reset();
    cyc(1'b1, 2'b00);
    chk("rnd_thr_above", err_o, 1);

    // thresh 0 never injects
    thresh_i = 16'h0000;
    do_reset();
    for (int i = 0; i < 1000; i++) cyc(1'b1, 2'b00);
    chk("rnd_thr0_ct", inj_sym_ct_o, 0);

    // thresh 0xFFFF over one full LFSR period
    thresh_i = 16'hFFFF;
    do_reset();
    for (int i = 0; i < 65535; i++) cyc(1'b1, 2'b00);
    chk("rnd_full_sym_ct", inj_sym_ct_o, 65534);
    chk("rnd_full_bit_ct", inj_bit_ct_o, 65534);
    valid_i = 1'b0;

    // ---- burst: first window armed at symbol 0 with offset 16, burst 18..21 ----
    mode_i      = 2'd2;
    burst_len_i = 4'd4;
    lane_mask_i = 2'b11;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      e = (i >= 18) && (i <= 21);
      cyc(1'b1, 2'b00);
      chk("burst_err", err_o, e);
      chk("burst_sym", sym_o, e ? 2'b11 : 2'b00);
      chk("burst_busy", busy_o, (i <= 20));
    end
    chk("burst_sym_ct", inj_sym_ct_o, 4);
    chk("burst_bit_ct", inj_bit_ct_o, 8);

    // longer run: every burst is 4 symbols and preceded by an armed state
    prev_err  = err_o;
    prev_busy = busy_o;
    run       = 0;
    err_total = 0;
    for (int i = 0; i < 32 * 62; i++) begin
      cyc(1'b1, 2'b00);
      if (err_o) begin
        if (!prev_err) chk("burst_armed_first", prev_busy, 1);
        run++;
        err_total++;
      end else if (prev_err) begin
        chk("burst_run_len", run, 4);
        run = 0;
      end
      prev_err  = err_o;
      prev_busy = busy_o;
    end
    chk("burst_runs_seen", (err_total > 0), 1);
    chk("burst_long_sym_ct", inj_sym_ct_o, 4 + err_total);
    chk("burst_long_bit_ct", inj_bit_ct_o, 2 * (4 + err_total));

    // ---- burst with gaps: invalid cycles must not move win_ct or the LFSR ----
    do_reset();
    for (int i = 0; i < 24; i++) begin
      e = (i >= 18) && (i <= 21);
      cyc(1'b1, 2'b00);
      chk("bgap_err", err_o, e);
      cyc(1'b0, 2'b00);
      chk("bgap_idle_err", err_o, 0);
      chk("bgap_idle_valid", valid_o, 0);
    end

    // ---- mode change aborts a burst ----
    mode_i = 2'd2;
    do_reset();
    for (int i = 0; i < 19; i++) cyc(1'b1, 2'b00);
    chk("abort_pre_err", err_o, 1);
    chk("abort_pre_busy", busy_o, 1);
    mode_i = 2'd0;
    cyc(1'b1, 2'b00);
    chk("abort_err", err_o, 0);
    chk("abort_sym", sym_o, 0);
    chk("abort_busy", busy_o, 0);

    // ---- asynchronous reset mid-burst, then identical replay ----
    mode_i = 2'd2;
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 2'b00);
    chk("rstmid_pre_err", err_o, 1);
    rst = 1'b1;
    #1;
    chk_reset_state("rstmid");
    do_reset();
    for (int i = 0; i < 24; i++) begin
      e = (i >= 18) && (i <= 21);
      cyc(1'b1, 2'b00);
      chk("replay_err", err_o, e);
    end
    chk("replay_sym_ct", inj_sym_ct_o, 4);

    valid_i = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
